// File: rtl/burst_slave_port.sv
// burst_slave_port
//   Serial-to-parallel slave port. Takes a header, a serial address (MSB
//   first) and serial write data (LSB first) from the bit-serial
//   interconnect. It then runs parallel request/acknowledge handshakes with
//   the target and returns read data serially (LSB first). Multi-beat bursts
//   auto-increment the address, which wraps modulo 2^ADDR_W.
//
// Ports
//   in_clk         clock, rising edge
//   reset          synchronous active-high reset
//   ss             slave select; dropping it outside IDLE aborts
//   ser_in_valid   qualifies header / in_addr / ser_wdata bits
//   in_write       header: 1=write, 0=read
//   burst_en       header: burst request
//   burst_len      header: beats minus 1
//   in_addr        serial address bit, MSB first
//   ser_wdata      serial write data bit, LSB first
//   ser_in_ready   interconnect accepts the current read bit
//   ser_rdata      serial read data bit, LSB first
//   ser_out_valid  ser_rdata valid
//   busy           state != IDLE
//   par_ack        target acceptance; par_rdata valid on reads
//   par_rdata      target read data
//   par_req        request to target
//   out_write      request is a write
//   out_addr       target address
//   par_wdata      target write data
//
// state      | meaning
// -----------+----------------------------------------------
// S_IDLE     | waiting for a header cycle
// S_RX_ADDR  | shifting in address bits
// S_RX_WDATA | shifting in one beat of write data
// S_WR_TGT   | write request held until par_ack
// S_RD_TGT   | read request held until par_ack
// S_TX_RDATA | shifting out one beat of read data

module burst_slave_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BURST_W = 4
) (
  input  logic               in_clk,
  input  logic               reset,
  input  logic               ss,
  input  logic               ser_in_valid,
  input  logic               in_write,
  input  logic               burst_en,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               in_addr,
  input  logic               ser_wdata,
  input  logic               ser_in_ready,
  output logic               ser_rdata,
  output logic               ser_out_valid,
  output logic               busy,
  input  logic               par_ack,
  input  logic [DATA_W-1:0]  par_rdata,
  output logic               par_req,
  output logic               out_write,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [DATA_W-1:0]  par_wdata
);

  localparam int BW1   = BURST_W + 1;
  localparam int CNT_W = (ADDR_W > DATA_W) ? $clog2(ADDR_W) : $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_WDATA,
    S_WR_TGT,
    S_RD_TGT,
    S_TX_RDATA
  } state_t;

  state_t             state;
  logic               wr_q;
  logic [BW1-1:0]     beats_left;
  logic [CNT_W-1:0]   bit_cnt;     // down-counter, terminal count at zero
  logic [DATA_W-1:0]  rdata_sh;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state         <= S_IDLE;
      wr_q          <= 1'b0;
      beats_left    <= '0;
      bit_cnt       <= '0;
      rdata_sh      <= '0;
      ser_rdata     <= 1'b0;
      ser_out_valid <= 1'b0;
      busy          <= 1'b0;
      par_req       <= 1'b0;
      out_write     <= 1'b0;
      out_addr      <= '0;
      par_wdata     <= '0;
    end else if (state != S_IDLE && !ss) begin
      // Abort wins over everything, including a same-cycle par_ack.
      state         <= S_IDLE;
      busy          <= 1'b0;
      par_req       <= 1'b0;
      out_write     <= 1'b0;
      ser_out_valid <= 1'b0;
      ser_rdata     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ss && ser_in_valid) begin
            wr_q       <= in_write;
            beats_left <= burst_en ? BW1'(burst_len) + BW1'(1) : BW1'(1);
            bit_cnt    <= CNT_W'(ADDR_W - 1);
            busy       <= 1'b1;
            state      <= S_RX_ADDR;
          end
        end

        S_RX_ADDR: begin
          if (ser_in_valid) begin
            out_addr <= {out_addr[ADDR_W-2:0], in_addr};
            if (bit_cnt == '0) begin
              if (wr_q) begin
                bit_cnt <= CNT_W'(DATA_W - 1);
                state   <= S_RX_WDATA;
              end else begin
                par_req   <= 1'b1;
                out_write <= 1'b0;
                state     <= S_RD_TGT;
              end
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end

        S_RX_WDATA: begin
          if (ser_in_valid) begin
            par_wdata <= {ser_wdata, par_wdata[DATA_W-1:1]};
            if (bit_cnt == '0) begin
              par_req   <= 1'b1;
              out_write <= 1'b1;
              state     <= S_WR_TGT;
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end

        S_WR_TGT: begin
          if (par_ack) begin
            par_req   <= 1'b0;
            out_write <= 1'b0;
            if (beats_left > BW1'(1)) begin
              beats_left <= beats_left - BW1'(1);
              out_addr   <= out_addr + ADDR_W'(1);
              bit_cnt    <= CNT_W'(DATA_W - 1);
              state      <= S_RX_WDATA;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        S_RD_TGT: begin
          if (par_ack) begin
            par_req       <= 1'b0;
            rdata_sh      <= par_rdata;
            ser_rdata     <= par_rdata[0];
            ser_out_valid <= 1'b1;
            bit_cnt       <= CNT_W'(DATA_W - 1);
            state         <= S_TX_RDATA;
          end
        end

        S_TX_RDATA: begin
          if (ser_in_ready) begin
            if (bit_cnt == '0) begin
              ser_out_valid <= 1'b0;
              ser_rdata     <= 1'b0;
              if (beats_left > BW1'(1)) begin
                beats_left <= beats_left - BW1'(1);
                out_addr   <= out_addr + ADDR_W'(1);
                par_req    <= 1'b1;
                out_write  <= 1'b0;
                state      <= S_RD_TGT;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              // ser_rdata is registered, so present the next bit from the
              // shift register before it shifts.
              bit_cnt   <= bit_cnt - CNT_W'(1);
              rdata_sh  <= rdata_sh >> 1;
              ser_rdata <= rdata_sh[1];
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_slave_port.sv
// tb_burst_slave_port
//   Directed bench for burst_slave_port. Inputs are driven and outputs
//   sampled on the falling edge of in_clk; the DUT acts on the rising edge.

module tb_burst_slave_port;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 4;

  logic               in_clk = 1'b0;
  logic               reset = 1'b1;
  logic               ss = 1'b0;
  logic               ser_in_valid = 1'b0;
  logic               in_write = 1'b0;
  logic               burst_en = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               in_addr = 1'b0;
  logic               ser_wdata = 1'b0;
  logic               ser_in_ready = 1'b0;
  logic               par_ack = 1'b0;
  logic [DATA_W-1:0]  par_rdata = '0;
  logic               ser_rdata;
  logic               ser_out_valid;
  logic               busy;
  logic               par_req;
  logic               out_write;
  logic [ADDR_W-1:0]  out_addr;
  logic [DATA_W-1:0]  par_wdata;

  burst_slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .in_clk(in_clk), .reset(reset), .ss(ss), .ser_in_valid(ser_in_valid),
    .in_write(in_write), .burst_en(burst_en), .burst_len(burst_len),
    .in_addr(in_addr), .ser_wdata(ser_wdata), .ser_in_ready(ser_in_ready),
    .ser_rdata(ser_rdata), .ser_out_valid(ser_out_valid), .busy(busy),
    .par_ack(par_ack), .par_rdata(par_rdata), .par_req(par_req),
    .out_write(out_write), .out_addr(out_addr), .par_wdata(par_wdata)
  );

  always #5 in_clk = ~in_clk;

  int n_chk = 0;
  int n_err = 0;
  int req_rises = 0;

  always @(posedge par_req) req_rises++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge in_clk);
  endtask

  // Header fields are scrambled right after the header cycle so that any
  // re-sampling mid-transaction would show up.
  task automatic send_header(input logic wr, input logic ben, input logic [BURST_W-1:0] blen);
    ss = 1'b1; ser_in_valid = 1'b1;
    in_write = wr; burst_en = ben; burst_len = blen;
    step();
    in_write = ~wr; burst_en = ~ben; burst_len = ~blen;
    ser_in_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] gaps);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      if (gaps[i]) begin
        ser_in_valid = 1'b0; in_addr = ~a[i]; step();
      end
      ser_in_valid = 1'b1; in_addr = a[i]; step();
    end
    ser_in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] gaps);
    for (int i = 0; i < DATA_W; i++) begin
      if (gaps[i]) begin
        ser_in_valid = 1'b0; ser_wdata = ~d[i]; step();
      end
      ser_in_valid = 1'b1; ser_wdata = d[i]; step();
    end
    ser_in_valid = 1'b0;
  endtask

  task automatic do_ack(input string tag, input int delay, input logic [DATA_W-1:0] rd);
    for (int i = 0; i < delay; i++) step();
    check_val({tag, "_req_held"}, par_req, 1);
    par_rdata = rd; par_ack = 1'b1;
    step();
    par_ack = 1'b0; par_rdata = '0;
  endtask

  task automatic recv_byte(input string tag, input logic [DATA_W-1:0] exp, input logic stall);
    logic [DATA_W-1:0] got;
    int idx;
    logic rdy;
    got = '0; idx = 0; rdy = 1'b1;
    for (int c = 0; c < 4 * DATA_W && idx < DATA_W; c++) begin
      check_val({tag, "_vld"}, ser_out_valid, 1);
      check_val({tag, "_bit"}, ser_rdata, exp[idx]);
      got[idx] = ser_rdata;
      ser_in_ready = rdy;
      step();
      if (rdy) idx++;
      if (stall) rdy = ~rdy;
    end
    ser_in_ready = 1'b0;
    check_val({tag, "_nbits"}, idx, DATA_W);
    check_val({tag, "_byte"}, got, exp);
  endtask

  logic [ADDR_W-1:0] t3_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
  logic [DATA_W-1:0] t3_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DATA_W-1:0] t4_data [2] = '{8'h5A, 8'h96};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [ADDR_W-1:0] ab;

    // Reset state
    reset = 1'b1; step(); step();
    check_val("rst_busy", busy, 0);
    check_val("rst_req", par_req, 0);
    check_val("rst_wr", out_write, 0);
    check_val("rst_vld", ser_out_valid, 0);
    check_val("rst_rdata", ser_rdata, 0);
    check_val("rst_addr", out_addr, 0);
    check_val("rst_wdata", par_wdata, 0);
    reset = 1'b0; step();

    // 1: single write
    r0 = req_rises;
    send_header(1'b1, 1'b0, 4'd0);
    check_val("t1_busy", busy, 1);
    send_addr(12'hA5C, '0);
    check_val("t1_no_req_yet", par_req, 0);
    send_data(8'h3E, '0);
    check_val("t1_req", par_req, 1);
    check_val("t1_wr", out_write, 1);
    check_val("t1_addr", out_addr, 12'hA5C);
    check_val("t1_wdata", par_wdata, 8'h3E);
    do_ack("t1", 2, 8'h00);
    check_val("t1_req_drop", par_req, 0);
    check_val("t1_busy_end", busy, 0);
    check_val("t1_nreq", req_rises - r0, 1);
    ss = 1'b0; step();

    // 2: single read, stalled address bits, ack after 3 cycles
    send_header(1'b0, 1'b0, 4'd0);
    send_addr(12'h3C1, 12'b0001_0010_0000);
    check_val("t2_req", par_req, 1);
    check_val("t2_wr", out_write, 0);
    check_val("t2_addr", out_addr, 12'h3C1);
    check_val("t2_vld_pre", ser_out_valid, 0);
    do_ack("t2", 3, 8'hC7);
    check_val("t2_req_drop", par_req, 0);
    recv_byte("t2", 8'hC7, 1'b0);
    check_val("t2_vld_end", ser_out_valid, 0);
    check_val("t2_busy_end", busy, 0);
    ss = 1'b0; step();

    // 3: 4-beat burst write across the address wrap
    send_header(1'b1, 1'b1, 4'd3);
    send_addr(12'hFFE, '0);
    for (int b = 0; b < 4; b++) begin
      send_data(t3_data[b], (b == 1) ? 8'b0010_0100 : 8'h00);
      check_val("t3_req", par_req, 1);
      check_val("t3_wr", out_write, 1);
      check_val("t3_addr", out_addr, t3_addr[b]);
      check_val("t3_wdata", par_wdata, t3_data[b]);
      do_ack("t3", b, 8'h00);
      check_val("t3_req_drop", par_req, 0);
      check_val("t3_busy", busy, (b < 3) ? 1 : 0);
    end
    ss = 1'b0; step();

    // 4: 2-beat burst read with ser_in_ready toggling
    send_header(1'b0, 1'b1, 4'd1);
    send_addr(12'h010, '0);
    for (int b = 0; b < 2; b++) begin
      check_val("t4_req", par_req, 1);
      check_val("t4_wr", out_write, 0);
      check_val("t4_addr", out_addr, 12'h010 + 12'(b));
      do_ack("t4", 1, t4_data[b]);
      recv_byte("t4", t4_data[b], 1'b1);
    end
    check_val("t4_busy_end", busy, 0);
    check_val("t4_vld_end", ser_out_valid, 0);
    ss = 1'b0; step();

    // 5: abort after 5 address bits, then a clean write
    r0 = req_rises;
    send_header(1'b1, 1'b0, 4'd0);
    ab = 12'hB6D;
    for (int i = ADDR_W - 1; i > ADDR_W - 6; i--) begin
      if (i == 10 || i == 8) begin
        ser_in_valid = 1'b0; step();
      end
      ser_in_valid = 1'b1; in_addr = ab[i]; step();
    end
    check_val("t5_busy_mid", busy, 1);
    ss = 1'b0; ser_in_valid = 1'b0; step();
    check_val("t5_busy_abort", busy, 0);
    check_val("t5_req_abort", par_req, 0);
    step();
    check_val("t5_busy_idle", busy, 0);
    check_val("t5_nreq", req_rises - r0, 0);
    send_header(1'b1, 1'b0, 4'd0);
    send_addr(12'h5A3, '0);
    send_data(8'h96, '0);
    check_val("t5_req", par_req, 1);
    check_val("t5_addr", out_addr, 12'h5A3);
    check_val("t5_wdata", par_wdata, 8'h96);
    do_ack("t5", 1, 8'h00);
    check_val("t5_busy_end", busy, 0);
    ss = 1'b0; step();

    // 6: reset while the write request is outstanding
    send_header(1'b1, 1'b0, 4'd0);
    send_addr(12'h7FF, '0);
    send_data(8'hFF, '0);
    check_val("t6_req", par_req, 1);
    step(); step();
    check_val("t6_req_held", par_req, 1);
    reset = 1'b1; step();
    check_val("t6_req", par_req, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_addr", out_addr, 0);
    check_val("t6_wdata", par_wdata, 0);
    check_val("t6_wr", out_write, 0);
    reset = 1'b0; ss = 1'b0; step();
    check_val("t6_busy_after", busy, 0);

    // 7: abort during an outstanding read request, ack in the same cycle
    send_header(1'b0, 1'b0, 4'd0);
    send_addr(12'h123, '0);
    check_val("t7_req", par_req, 1);
    ss = 1'b0; par_ack = 1'b1; par_rdata = 8'hFF; step();
    par_ack = 1'b0; par_rdata = '0;
    check_val("t7_req_drop", par_req, 0);
    check_val("t7_busy", busy, 0);
    check_val("t7_vld", ser_out_valid, 0);
    step();
    check_val("t7_vld_idle", ser_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/burst_slave_port.md
Name: burst_slave_port

Overview:
Parametrised next-generation serial-to-parallel slave port between the bit-serial interconnect and a parallel target (slave memory or peripheral).
- Receives a header, a serial address and serial write data from the interconnect.
- Performs parallel read/write handshakes with the target.
- Returns read data serially.
- Adds multi-beat bursts with address auto-increment, input stall handling and abort on slave-select drop.

Parameters:
ADDR_W, 12, address width in bits (serial address length)
DATA_W, 8, data width in bits (serial beat length)
BURST_W, 4, burst length field width; max beats = 2^BURST_W

Ports:
in_clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ss  input  1  slave select from interconnect; high for whole transaction
ser_in_valid  input  1  interconnect bit qualifier for header/in_addr/ser_wdata
in_write  input  1  1=write, 0=read; sampled on header cycle
burst_en  input  1  burst request; sampled on header cycle
burst_len  input  BURST_W  beats minus 1; sampled on header cycle, ignored if burst_en=0
in_addr  input  1  serial address bit, MSB first
ser_wdata  input  1  serial write data bit, LSB first
ser_in_ready  input  1  interconnect ready to accept read bit
ser_rdata  output  1  serial read data bit, LSB first
ser_out_valid  output  1  ser_rdata valid
busy  output  1  high whenever state != IDLE
par_ack  input  1  target acceptance; on reads, par_rdata valid this cycle
par_rdata  input  DATA_W  target read data
par_req  output  1  request to target
out_write  output  1  request is write
out_addr  output  ADDR_W  target address (registered)
par_wdata  output  DATA_W  target write data (registered)

Behaviour:
- Reset: state=IDLE.
  - Outputs ser_rdata, ser_out_valid, busy, par_req, out_write = 0.
  - out_addr = 0, par_wdata = 0.
  - Counters = 0.
  - Reset mid-transaction takes priority over all else; any outstanding par_req drops in the reset cycle's next edge.
- Bit transfer: only cycles with ss=1 and ser_in_valid=1 advance receive counters. ser_in_valid=0 stalls with state held.
- FSM states and transitions:
  - IDLE: ss&ser_in_valid -> latch in_write, beats = burst_en ? burst_len+1 : 1 -> RX_ADDR.
  - RX_ADDR: shift in ADDR_W bits MSB first into out_addr. After bit ADDR_W -> RX_WDATA if write, RD_TGT if read.
  - RX_WDATA: shift DATA_W bits LSB first into par_wdata. After bit DATA_W -> WR_TGT.
  - WR_TGT: par_req=1, out_write=1 held until par_ack.
    - On ack: beats_left>1 -> out_addr+1, RX_WDATA.
    - Otherwise -> IDLE.
  - RD_TGT: par_req=1, out_write=0 until par_ack. On ack, latch par_rdata -> TX_RDATA.
  - TX_RDATA: ser_out_valid=1, ser_rdata = current bit. Bit index advances only on cycles with ser_in_ready=1.
    - After bit DATA_W-1 accepted: beats_left>1 -> out_addr+1, RD_TGT.
    - Otherwise -> IDLE.
- Latency: par_req rises the cycle after the last address bit (read) or last data bit (write) is sampled. Read data first bit appears the cycle after par_ack.
- par_req drops the cycle after par_ack. A par_ack while par_req=0 is ignored.
- Address increment wraps modulo 2^ADDR_W (e.g. all-ones -> 0).
- Burst header is sampled once; burst_en/burst_len changes mid-burst are ignored.
- ss=0 in any non-IDLE state aborts: next cycle state=IDLE and par_req=0, even without ack.
- Abort in the same cycle as par_ack: the access counts as done; still -> IDLE.
- ser_out_valid=0 outside TX_RDATA.

Test Plan:
1. Single write: header in_write=1, burst_en=0; addr 0xA5C; data 0x3E; par_ack 2 cycles after par_req -> one par_req, out_write=1, out_addr=0xA5C, par_wdata=0x3E; busy low the cycle after ack.
2. Single read, ack delayed 3 cycles, par_rdata=0xC7, ser_in_ready=1 -> ser_rdata bits 1,1,1,0,0,0,1,1 on 8 consecutive ser_out_valid cycles.
3. Burst write: burst_len=3 at addr 0xFFE, data 0x11,0x22,0x33,0x44 -> four writes to 0xFFE, 0xFFF, 0x000, 0x001 with matching data.
4. Burst read with stalls: burst_len=1, addr 0x010, ser_in_ready toggling 1/0 -> each bit held while ready=0; 2 reads at 0x010, 0x011; 16 bits total delivered in order.
5. Abort: ss dropped after 5 address bits, ser_in_valid gaps inserted earlier -> IDLE next cycle; par_req never asserted; next clean transaction works.
6. Reset asserted during WR_TGT with par_ack never given -> next cycle par_req=0, busy=0, out_addr=0, par_wdata=0.
